// File: rtl/mem_scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : mem_scan_seq
// Purpose  : Block sequencer for the scan-side SRAM access path. Runs FILL
//            (write), DUMP (read out) and CHECK (read and compare) over a
//            contiguous, wrapping address range. Each word is presented on
//            scan_addr/scan_d/scan_wen_n and launched with one toggle of
//            mem_trigger into the mem scan mux.
// Ports    : CLK, mem_seq_reset_n      clock, synchronous active-low reset
//            start/cmd/base_addr/count/pattern/pat_inc/abort   command side
//            scan_q                    captured read data from the scan mux
//            mem_use_scan/scan_mem_sel/mem_trigger/scan_addr/scan_d/
//            scan_wen_n/scan_cen_n     drive into the mem scan mux
//            busy/done/aborted         command status
//            rd_valid/rd_data/rd_addr  read-out stream (DUMP and CHECK)
//            err/err_count/first_err_addr   CHECK results
// Revision : 1.0  initial release
// ============================================================================
module mem_scan_seq #(
    parameter int addrbits = 16,
    parameter int dqbits   = 32,
    parameter int SETTLE   = 7
) (
    input  logic                CLK,
    input  logic                mem_seq_reset_n,
    input  logic                start,
    input  logic [1:0]          cmd,
    input  logic [addrbits-1:0] base_addr,
    input  logic [addrbits-1:0] count,
    input  logic [dqbits-1:0]   pattern,
    input  logic                pat_inc,
    input  logic                abort,
    input  logic [dqbits-1:0]   scan_q,
    output logic                mem_use_scan,
    output logic                scan_mem_sel,
    output logic                mem_trigger,
    output logic [addrbits-1:0] scan_addr,
    output logic [dqbits-1:0]   scan_d,
    output logic                scan_wen_n,
    output logic                scan_cen_n,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                rd_valid,
    output logic [dqbits-1:0]   rd_data,
    output logic [addrbits-1:0] rd_addr,
    output logic                err,
    output logic [addrbits-1:0] err_count,
    output logic [addrbits-1:0] first_err_addr
);

    localparam logic [1:0] c_CMD_FILL  = 2'b00;
    localparam logic [1:0] c_CMD_CHECK = 2'b10;
    localparam logic [1:0] c_CMD_RSVD  = 2'b11;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_TRIG  = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_NEXT  = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    localparam int c_WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [2:0]          r_state;
    logic [1:0]          r_cmd;
    logic [dqbits-1:0]   r_pattern;
    logic                r_pat_inc;
    logic [addrbits-1:0] r_remaining;
    logic [addrbits-1:0] r_index;
    logic [c_WW-1:0]     r_wait;
    logic                r_abort_pend;
    logic                r_end_abort;

    logic [addrbits-1:0] w_next_idx;
    logic [dqbits-1:0]   w_next_data;
    logic                w_abort;

    assign w_next_idx  = r_index + 1'b1;
    assign w_next_data = r_pattern + (r_pat_inc ? dqbits'(w_next_idx) : '0);
    // An abort arriving in the NEXT cycle itself still stops the sequence.
    assign w_abort     = r_abort_pend | abort;

    always_ff @(posedge CLK) begin
        if (!mem_seq_reset_n) begin
            r_state        <= c_ST_IDLE;
            r_cmd          <= '0;
            r_pattern      <= '0;
            r_pat_inc      <= 1'b0;
            r_remaining    <= '0;
            r_index        <= '0;
            r_wait         <= '0;
            r_abort_pend   <= 1'b0;
            r_end_abort    <= 1'b0;
            mem_use_scan   <= 1'b0;
            scan_mem_sel   <= 1'b0;  // drops with mem_trigger so its forced edge is ignored
            mem_trigger    <= 1'b0;
            scan_addr      <= '0;
            scan_d         <= '0;
            scan_wen_n     <= 1'b1;
            scan_cen_n     <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            aborted        <= 1'b0;
            rd_valid       <= 1'b0;
            rd_data        <= '0;
            rd_addr        <= '0;
            err            <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;

            if (r_state != c_ST_IDLE && abort) begin
                r_abort_pend <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (start && cmd != c_CMD_RSVD) begin
                        r_cmd          <= cmd;
                        r_pattern      <= pattern;
                        r_pat_inc      <= pat_inc;
                        r_remaining    <= count;
                        r_index        <= '0;
                        r_abort_pend   <= 1'b0;  // start beats a coincident abort
                        r_end_abort    <= 1'b0;
                        busy           <= 1'b1;
                        mem_use_scan   <= 1'b1;
                        scan_mem_sel   <= 1'b1;
                        scan_cen_n     <= 1'b0;
                        aborted        <= 1'b0;
                        err            <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        if (count == '0) begin
                            r_state <= c_ST_DONE;
                        end else begin
                            scan_addr  <= base_addr;
                            scan_d     <= pattern;
                            scan_wen_n <= (cmd != c_CMD_FILL);
                            r_state    <= c_ST_SETUP;
                        end
                    end
                end

                c_ST_SETUP: begin
                    r_state <= c_ST_TRIG;
                end

                c_ST_TRIG: begin
                    mem_trigger <= ~mem_trigger;
                    r_wait      <= c_WW'(SETTLE - 1);
                    r_state     <= c_ST_WAIT;
                end

                c_ST_WAIT: begin
                    if (r_wait == '0) begin
                        if (r_cmd != c_CMD_FILL) begin
                            rd_valid <= 1'b1;
                            rd_data  <= scan_q;
                            rd_addr  <= scan_addr;
                            // scan_d already holds the expected word for this address
                            if (r_cmd == c_CMD_CHECK && scan_q != scan_d) begin
                                err <= 1'b1;
                                if (err_count != '1) begin
                                    err_count <= err_count + 1'b1;
                                end
                                if (!err) begin
                                    first_err_addr <= scan_addr;
                                end
                            end
                        end
                        r_state <= c_ST_NEXT;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end

                c_ST_NEXT: begin
                    if (r_remaining == addrbits'(1) || w_abort) begin
                        r_end_abort <= (r_remaining != addrbits'(1));
                        r_state     <= c_ST_DONE;
                    end else begin
                        scan_addr   <= scan_addr + 1'b1;
                        scan_d      <= w_next_data;
                        r_index     <= w_next_idx;
                        r_remaining <= r_remaining - 1'b1;
                        r_state     <= c_ST_SETUP;
                    end
                end

                c_ST_DONE: begin
                    done         <= 1'b1;
                    aborted      <= r_end_abort;
                    busy         <= 1'b0;
                    mem_use_scan <= 1'b0;
                    scan_mem_sel <= 1'b0;
                    scan_cen_n   <= 1'b1;
                    scan_wen_n   <= 1'b1;
                    r_abort_pend <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_scan_seq
// Purpose  : Self-checking bench for mem_scan_seq. An SRAM model reacts to
//            mem_trigger toggles (write on wen_n=0, delayed capture on read);
//            a word-level reference memory predicts contents, read streams,
//            CHECK results and command latency.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_scan_seq;

    localparam int AB = 16;
    localparam int DB = 32;
    localparam int S  = 7;
    localparam int WP = S + 3;

    logic          CLK = 1'b0;
    logic          mem_seq_reset_n;
    logic          start;
    logic [1:0]    cmd;
    logic [AB-1:0] base_addr;
    logic [AB-1:0] count;
    logic [DB-1:0] pattern;
    logic          pat_inc;
    logic          abort;
    logic [DB-1:0] scan_q;
    logic          mem_use_scan, scan_mem_sel, mem_trigger;
    logic [AB-1:0] scan_addr;
    logic [DB-1:0] scan_d;
    logic          scan_wen_n, scan_cen_n, busy, done, aborted, rd_valid;
    logic [DB-1:0] rd_data;
    logic [AB-1:0] rd_addr;
    logic          err;
    logic [AB-1:0] err_count, first_err_addr;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_scan_seq #(.addrbits(AB), .dqbits(DB), .SETTLE(S)) dut (
        .CLK(CLK), .mem_seq_reset_n(mem_seq_reset_n), .start(start), .cmd(cmd),
        .base_addr(base_addr), .count(count), .pattern(pattern), .pat_inc(pat_inc),
        .abort(abort), .scan_q(scan_q), .mem_use_scan(mem_use_scan),
        .scan_mem_sel(scan_mem_sel), .mem_trigger(mem_trigger), .scan_addr(scan_addr),
        .scan_d(scan_d), .scan_wen_n(scan_wen_n), .scan_cen_n(scan_cen_n), .busy(busy),
        .done(done), .aborted(aborted), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_addr(rd_addr), .err(err), .err_count(err_count), .first_err_addr(first_err_addr)
    );

    // ---------------- SRAM / scan mux model (written only here) -------------
    logic [DB-1:0] mem [0:65535];
    logic          last_trig = 1'b0;
    int            toggles   = 0;
    int            writes    = 0;
    int            rd_pend   = 0;
    logic [AB-1:0] rd_lat    = '0;
    logic [AB-1:0] rdq_addr [$];
    logic [DB-1:0] rdq_data [$];

    always @(posedge CLK) begin
        if (rd_pend > 0) begin
            rd_pend = rd_pend - 1;
            if (rd_pend == 0) scan_q <= mem[rd_lat];
        end
        if (mem_trigger !== last_trig) begin
            if (scan_mem_sel === 1'b1) begin
                toggles = toggles + 1;
                if (scan_wen_n === 1'b0) begin
                    mem[scan_addr] = scan_d;
                    writes = writes + 1;
                end else begin
                    rd_lat  = scan_addr;
                    rd_pend = 5;
                    scan_q <= $urandom;  // garbage until the capture settles
                end
            end
            last_trig = mem_trigger;
        end
        if (rd_valid === 1'b1) begin
            rdq_addr.push_back(rd_addr);
            rdq_data.push_back(rd_data);
        end
    end

    // ---------------- reference model -----------------------------------------
    logic [DB-1:0] exp_mem [int];

    function automatic logic [DB-1:0] word_of(input logic [DB-1:0] p, input logic pi, input int i);
        return pi ? p + DB'(i) : p;
    endfunction

    function automatic void model_fill(input logic [AB-1:0] b, input int n,
                                       input logic [DB-1:0] p, input logic pi);
        for (int i = 0; i < n; i++) exp_mem[int'(AB'(b + AB'(i)))] = word_of(p, pi, i);
    endfunction

    // ---------------- command driver --------------------------------------------
    task automatic run_cmd(input logic [1:0] c, input logic [AB-1:0] b, input logic [AB-1:0] n,
                           input logic [DB-1:0] p, input logic pi, input int abort_word,
                           input int poke_cyc, output int cyc, output int tog, output int wr,
                           output int rdn, output int rfirst, output bit to);
        int t0, w0;
        bit sent;
        @(negedge CLK);
        t0 = toggles; w0 = writes; rfirst = rdq_addr.size(); sent = 0; to = 0;
        cmd = c; base_addr = b; count = n; pattern = p; pat_inc = pi; start = 1'b1;
        @(posedge CLK);
        cyc = 1;
        @(negedge CLK);
        start = 1'b0;
        while (done !== 1'b1) begin
            abort = 1'b0;
            start = 1'b0;
            if (abort_word > 0 && !sent && (toggles - t0) == abort_word) begin
                abort = 1'b1;
                sent  = 1;
            end
            if (poke_cyc > 0 && cyc == poke_cyc) begin
                start = 1'b1;
                cmd   = 2'b01;
            end
            if (cyc > 5000) begin
                to = 1;
                break;
            end
            @(posedge CLK);
            cyc++;
            @(negedge CLK);
        end
        abort = 1'b0;
        start = 1'b0;
        tog = toggles - t0;
        wr  = writes - w0;
        rdn = rdq_addr.size() - rfirst;
    endtask

    // ---------------- scenarios ---------------------------------------------
    task automatic test_reset();
        mem_seq_reset_n = 1'b0;
        start = 0; cmd = 0; base_addr = 0; count = 0; pattern = 0; pat_inc = 0; abort = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({busy, done, aborted, rd_valid, err, mem_use_scan, scan_mem_sel, mem_trigger} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags got %b expected 00000000",
                     {busy, done, aborted, rd_valid, err, mem_use_scan, scan_mem_sel, mem_trigger});
        end
        checks++;
        if ({scan_wen_n, scan_cen_n} !== 2'b11 || scan_addr !== '0 || scan_d !== '0 ||
            err_count !== '0 || first_err_addr !== '0 || rd_addr !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_values got wen/cen=%b addr=%h d=%h ec=%h fea=%h expected 11/0/0/0/0",
                     {scan_wen_n, scan_cen_n}, scan_addr, scan_d, err_count, first_err_addr);
        end
        mem_seq_reset_n = 1'b1;
    endtask

    task automatic test_fill();
        int cyc, tog, wr, rdn, rf, bad;
        bit to;
        run_cmd(2'b00, 16'h0010, 16'd4, 32'hA5A50000, 1'b1, 0, 0, cyc, tog, wr, rdn, rf, to);
        model_fill(16'h0010, 4, 32'hA5A50000, 1'b1);
        checks++;
        if (to || cyc !== 4 * WP + 2) begin
            errors++;
            $display("FAIL fill_latency got %0d (timeout=%0d) expected %0d", cyc, to, 4 * WP + 2);
        end
        checks++;
        if (tog !== 4 || wr !== 4 || rdn !== 0) begin
            errors++;
            $display("FAIL fill_counts got toggles=%0d writes=%0d rd=%0d expected 4 4 0", tog, wr, rdn);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) if (mem[16'h0010 + i] !== 32'hA5A50000 + DB'(i)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL fill_data got %0d bad words expected 0 (mem[12]=%h)", bad, mem[16'h0012]);
        end
        checks++;
        if (busy !== 1'b0 || mem_use_scan !== 1'b0 || scan_cen_n !== 1'b1 || aborted !== 1'b0) begin
            errors++;
            $display("FAIL fill_end got busy=%b use=%b cen_n=%b aborted=%b expected 0 0 1 0",
                     busy, mem_use_scan, scan_cen_n, aborted);
        end
    endtask

    task automatic test_check();
        int cyc, tog, wr, rdn, rf;
        bit to;
        // corrupt one word through the DUT itself
        run_cmd(2'b00, 16'h0012, 16'd1, 32'hDEADBEEF, 1'b0, 0, 0, cyc, tog, wr, rdn, rf, to);
        model_fill(16'h0012, 1, 32'hDEADBEEF, 1'b0);
        run_cmd(2'b10, 16'h0010, 16'd4, 32'hA5A50000, 1'b1, 0, 0, cyc, tog, wr, rdn, rf, to);
        checks++;
        if (to || err !== 1'b1 || err_count !== 16'd1 || first_err_addr !== 16'h0012) begin
            errors++;
            $display("FAIL check_result got err=%b ec=%0d fea=%h expected 1 1 0012", err, err_count, first_err_addr);
        end
        checks++;
        if (rdn !== 4 || wr !== 0 || tog !== 4) begin
            errors++;
            $display("FAIL check_pulses got rd=%0d writes=%0d toggles=%0d expected 4 0 4", rdn, wr, tog);
        end
        checks++;
        if (rdq_data[rf + 2] !== 32'hDEADBEEF || rdq_addr[rf + 3] !== 16'h0013) begin
            errors++;
            $display("FAIL check_stream got data2=%h addr3=%h expected deadbeef 0013",
                     rdq_data[rf + 2], rdq_addr[rf + 3]);
        end
    endtask

    task automatic test_dump_wrap();
        int cyc, tog, wr, rdn, rf, bad;
        bit to;
        logic [DB-1:0] p;
        p = $urandom;
        run_cmd(2'b00, 16'hFFFE, 16'd3, p, 1'b1, 0, 0, cyc, tog, wr, rdn, rf, to);
        model_fill(16'hFFFE, 3, p, 1'b1);
        run_cmd(2'b01, 16'hFFFE, 16'd3, 32'h0, 1'b0, 0, 0, cyc, tog, wr, rdn, rf, to);
        checks++;
        if (to || rdn !== 3 || err !== 1'b0) begin
            errors++;
            $display("FAIL dump_count got rd=%0d err=%b expected 3 0", rdn, err);
        end else begin
            bad = 0;
            for (int i = 0; i < 3; i++) begin
                if (rdq_addr[rf + i] !== AB'(16'hFFFE + i)) bad++;
                if (rdq_data[rf + i] !== exp_mem[int'(AB'(16'hFFFE + i))]) bad++;
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL dump_wrap got addrs %h %h %h (%0d bad) expected fffe ffff 0000",
                         rdq_addr[rf], rdq_addr[rf + 1], rdq_addr[rf + 2], bad);
            end
        end
    endtask

    task automatic test_count_zero();
        int cyc, tog, wr, rdn, rf;
        bit to;
        logic trig0;
        trig0 = mem_trigger;
        run_cmd(2'b00, 16'h0040, 16'd0, 32'h1234, 1'b0, 0, 0, cyc, tog, wr, rdn, rf, to);
        checks++;
        if (to || cyc !== 2) begin
            errors++;
            $display("FAIL zero_latency got %0d expected 2", cyc);
        end
        checks++;
        if (tog !== 0 || rdn !== 0 || wr !== 0 || mem_trigger !== trig0) begin
            errors++;
            $display("FAIL zero_activity got toggles=%0d rd=%0d writes=%0d trig=%b expected 0 0 0 %b",
                     tog, rdn, wr, mem_trigger, trig0);
        end
    endtask

    task automatic test_abort();
        int cyc, tog, wr, rdn, rf;
        bit to;
        run_cmd(2'b00, 16'h0100, 16'd8, 32'h5555AAAA, 1'b0, 2, 0, cyc, tog, wr, rdn, rf, to);
        checks++;
        if (to || tog !== 2 || wr !== 2 || aborted !== 1'b1) begin
            errors++;
            $display("FAIL abort got toggles=%0d writes=%0d aborted=%b expected 2 2 1", tog, wr, aborted);
        end
        checks++;
        if (cyc !== 2 * WP + 2) begin
            errors++;
            $display("FAIL abort_latency got %0d expected %0d", cyc, 2 * WP + 2);
        end
        model_fill(16'h0100, 2, 32'h5555AAAA, 1'b0);
    endtask

    task automatic test_back_to_back();
        int cyc, tog, wr, rdn, rf;
        bit to;
        // a second start mid-operation must be ignored
        run_cmd(2'b00, 16'h0200, 16'd3, 32'h0BAD0000, 1'b1, 0, 5, cyc, tog, wr, rdn, rf, to);
        model_fill(16'h0200, 3, 32'h0BAD0000, 1'b1);
        checks++;
        if (to || wr !== 3 || rdn !== 0 || cyc !== 3 * WP + 2 || aborted !== 1'b0) begin
            errors++;
            $display("FAIL busy_start got writes=%0d rd=%0d cyc=%0d aborted=%b expected 3 0 %0d 0",
                     wr, rdn, cyc, aborted, 3 * WP + 2);
        end
        // reserved command must be ignored
        @(negedge CLK);
        cmd = 2'b11; count = 16'd2; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || scan_cen_n !== 1'b1 || mem_use_scan !== 1'b0) begin
            errors++;
            $display("FAIL reserved_cmd got busy=%b cen_n=%b use=%b expected 0 1 0", busy, scan_cen_n, mem_use_scan);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, tog, wr, rdn, rf, guard;
        bit to;
        int t0;
        @(negedge CLK);
        t0 = toggles;
        cmd = 2'b00; base_addr = 16'h0300; count = 16'd4; pattern = 32'h77; pat_inc = 1'b0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        guard = 0;
        while (toggles == t0 && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        repeat (2) @(negedge CLK);  // now inside WAIT
        mem_seq_reset_n = 1'b0;
        @(negedge CLK);
        checks++;
        if (guard >= 100 || busy !== 1'b0 || done !== 1'b0 || mem_trigger !== 1'b0 ||
            scan_mem_sel !== 1'b0 || scan_cen_n !== 1'b1 || scan_wen_n !== 1'b1 || mem_use_scan !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b done=%b trig=%b sel=%b cen_n=%b wen_n=%b expected 0 0 0 0 1 1",
                     busy, done, mem_trigger, scan_mem_sel, scan_cen_n, scan_wen_n);
        end
        mem_seq_reset_n = 1'b1;
        run_cmd(2'b00, 16'h0310, 16'd1, 32'hCAFEF00D, 1'b0, 0, 0, cyc, tog, wr, rdn, rf, to);
        checks++;
        if (to || wr !== 1 || tog !== 1 || mem[16'h0310] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL reset_recover got writes=%0d toggles=%0d data=%h expected 1 1 cafef00d",
                     wr, tog, mem[16'h0310]);
        end
        model_fill(16'h0310, 1, 32'hCAFEF00D, 1'b0);
    endtask

    task automatic test_random();
        int cyc, tog, wr, rdn, rf, bad, n, ec;
        bit to;
        logic [AB-1:0] b, fea;
        logic [DB-1:0] p, p2;
        logic pi, pi2;
        logic [1:0] op;
        for (int it = 0; it < 8; it++) begin
            b  = (it % 3 == 0) ? AB'(16'hFFFC + $urandom_range(0, 3)) : AB'($urandom);
            n  = $urandom_range(1, 6);
            p  = $urandom;
            pi = 1'($urandom_range(0, 1));
            run_cmd(2'b00, b, AB'(n), p, pi, 0, 0, cyc, tog, wr, rdn, rf, to);
            model_fill(b, n, p, pi);
            bad = 0;
            for (int i = 0; i < n; i++) if (mem[AB'(b + AB'(i))] !== exp_mem[int'(AB'(b + AB'(i)))]) bad++;
            checks++;
            if (to || cyc !== n * WP + 2 || wr !== n || bad !== 0) begin
                errors++;
                $display("FAIL rand_fill it=%0d got cyc=%0d writes=%0d bad=%0d expected %0d %0d 0",
                         it, cyc, wr, bad, n * WP + 2, n);
            end
            op  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            p2  = ($urandom_range(0, 1) == 0) ? p : DB'($urandom);
            pi2 = 1'($urandom_range(0, 1));
            run_cmd(op, b, AB'(n), p2, pi2, 0, 0, cyc, tog, wr, rdn, rf, to);
            bad = 0;
            ec  = 0;
            fea = '0;
            for (int i = 0; i < n; i++) begin
                if (rdn == n) begin
                    if (rdq_addr[rf + i] !== AB'(b + AB'(i))) bad++;
                    if (rdq_data[rf + i] !== exp_mem[int'(AB'(b + AB'(i)))]) bad++;
                end
                if (exp_mem[int'(AB'(b + AB'(i)))] !== word_of(p2, pi2, i)) begin
                    if (ec == 0) fea = AB'(b + AB'(i));
                    ec++;
                end
            end
            checks++;
            if (to || rdn !== n || bad !== 0 || wr !== 0) begin
                errors++;
                $display("FAIL rand_read it=%0d op=%0d got rd=%0d bad=%0d writes=%0d expected %0d 0 0",
                         it, op, rdn, bad, wr, n);
            end
            if (op == 2'b10) begin
                checks++;
                if (err_count !== AB'(ec) || err !== (ec > 0) || first_err_addr !== fea) begin
                    errors++;
                    $display("FAIL rand_check it=%0d got err=%b ec=%0d fea=%h expected %b %0d %h",
                             it, err, err_count, first_err_addr, (ec > 0), ec, fea);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_check();
        test_dump_wrap();
        test_count_zero();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
